uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm.sv | 116 +++++++++++
 tb/tb_uart_rx_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// UART receive controller: sequences start, data, optional parity and stop
// bits on an oversampled clock and strobes the external sampler, checkers
// and deserializer at the right oversample tick of each bit.
module uart_rx_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic [5:0] prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       dat_samp_en,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] ps;
    logic [5:0] last;
    logic [5:0] chk;
    logic       at_last;
    logic       at_chk;
    logic       err_flag;
    logic       start_det;

    // Unsupported oversampling ratios fall back to 8x.
    function automatic logic [5:0] legal_ps(input logic [5:0] p);
        case (p)
            6'd8, 6'd16, 6'd32: legal_ps = p;
            default:            legal_ps = 6'd8;
        endcase
    endfunction

    assign last      = ps - 6'd1;
    assign chk       = ps - 6'd2;
    assign at_last   = (edge_cnt == last);
    assign at_chk    = (edge_cnt == chk);
    assign start_det = (state == IDLE) && !rx_in;

    // Strobes come only from registered state and tick count, so they are glitch-free.
    assign dat_samp_en = (state != IDLE);
    assign strt_chk_en = (state == START)  && at_chk;
    assign deser_en    = (state == DATA)   && at_chk;
    assign par_chk_en  = (state == PARITY) && at_chk;
    assign stp_chk_en  = (state == STOP)   && at_chk;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; bit boundaries are the ticks where edge_cnt hits last.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (!rx_in) state_nxt = START;
            START:  if (at_last) state_nxt = strt_glitch ? IDLE : DATA;
            DATA:   if (at_last && (bit_cnt == 4'd8)) state_nxt = par_en ? PARITY : STOP;
            PARITY: if (at_last) state_nxt = STOP;
            STOP:   if (at_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tick and bit counters; cleared whenever the FSM is in or returning to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= 4'd0;
        end else if ((state == IDLE) || (state_nxt == IDLE)) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= 4'd0;
        end else if (at_last) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    // Frame-wide settings: ratio frozen at start detection, parity result held to the stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps       <= 6'd8;
            err_flag <= 1'b0;
        end else if (start_det) begin
            ps       <= legal_ps(prescale);
            err_flag <= 1'b0;
        end else if ((state == PARITY) && at_last) begin
            err_flag <= par_err;
        end
    end

    // One-cycle accept pulse after a frame with clean parity and stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) data_valid <= 1'b0;
        else     data_valid <= (state == STOP) && at_last && !err_flag && !stp_err;
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: the checker inputs are driven directly and
// strobe activity is tallied per cycle, then compared to hand-derived values.
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       par_en;
    logic [5:0] prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int n_deser, deser_bad, n_strt, strt_edge, n_par, par_edge, par_bit;
    int n_stp, stp_edge, n_dv, dv_cyc, multi, chk_exp;
    int len, d, dv_first, nb;

    uart_rx_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .par_en      (par_en),
        .prescale    (prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .strt_chk_en (strt_chk_en),
        .deser_en    (deser_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_deser = 0; deser_bad = 0; n_strt = 0; strt_edge = -1;
        n_par = 0; par_edge = -1; par_bit = -1; n_stp = 0; stp_edge = -1;
        n_dv = 0; dv_cyc = -1; multi = 0;
    endtask

    // Advance one clock and tally what the DUT shows after the edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (deser_en) begin
            n_deser++;
            if (int'(edge_cnt) != chk_exp) deser_bad++;
        end
        if (strt_chk_en) begin n_strt++; strt_edge = int'(edge_cnt); end
        if (par_chk_en)  begin n_par++; par_edge = int'(edge_cnt); par_bit = int'(bit_cnt); end
        if (stp_chk_en)  begin n_stp++; stp_edge = int'(edge_cnt); end
        if ((int'(strt_chk_en) + int'(deser_en) + int'(par_chk_en) + int'(stp_chk_en)) > 1) multi++;
        if (data_valid) begin n_dv++; dv_cyc = cyc; end
    endtask

    // Pull the line low to start a frame and run until the FSM is back in IDLE.
    task automatic frame(input int low_extra, input int chg_at, input logic [5:0] chg_val,
                         output int flen, output int det);
        int n;
        rx_in = 1'b0;
        step();
        det = cyc;
        repeat (low_extra) step();
        rx_in = 1'b1;
        n = 0;
        while (dat_samp_en && n < 1000) begin
            if (chg_at >= 0 && (cyc - det) == chg_at) prescale = chg_val;
            step();
            n++;
        end
        check("frame_returns_idle", int'(dat_samp_en), 0);
        flen = cyc - det;
    endtask

    initial begin
        rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0; chk_exp = 6;
        clr_stats();
        repeat (2) @(negedge clk);
        check("rst_samp_en", int'(dat_samp_en), 0);
        check("rst_edge_cnt", int'(edge_cnt), 0);
        check("rst_bit_cnt", int'(bit_cnt), 0);
        check("rst_strobes", int'({strt_chk_en, deser_en, par_chk_en, stp_chk_en}), 0);
        check("rst_data_valid", int'(data_valid), 0);
        rst = 1'b0;
        repeat (2) step();
        check("idle_holds", int'(dat_samp_en), 0);

        // Clean 8x frame without parity.
        clr_stats(); chk_exp = 6;
        frame(0, -1, 6'd0, len, d);
        check("f8_len", len, 80);
        check("f8_dv_latency", dv_cyc - d, 80);
        check("f8_deser_count", n_deser, 8);
        check("f8_deser_edge", deser_bad, 0);
        check("f8_strt_edge", strt_edge, 6);
        check("f8_stp_edge", stp_edge, 6);
        check("f8_par_count", n_par, 0);
        check("f8_dv_count", n_dv, 1);
        check("f8_exclusive", multi, 0);
        check("f8_idle_bit_cnt", int'(bit_cnt), 0);
        step();
        check("f8_dv_one_cycle", int'(data_valid), 0);

        // 16x frame with parity, parity checker reports an error.
        clr_stats(); chk_exp = 14; prescale = 6'd16; par_en = 1'b1; par_err = 1'b1;
        frame(0, -1, 6'd0, len, d);
        check("par_len", len, 176);
        check("par_chk_count", n_par, 1);
        check("par_chk_edge", par_edge, 14);
        check("par_chk_bit", par_bit, 9);
        check("par_deser_count", n_deser, 8);
        check("par_dv_count", n_dv, 0);
        check("par_exclusive", multi, 0);
        par_err = 1'b0; par_en = 1'b0;

        // Error flag from the previous frame must not leak into this one.
        clr_stats(); chk_exp = 6; prescale = 6'd8;
        frame(0, -1, 6'd0, len, d);
        check("clr_len", len, 80);
        check("clr_dv_count", n_dv, 1);

        // Bad stop bit.
        clr_stats(); stp_err = 1'b1;
        frame(0, -1, 6'd0, len, d);
        check("stp_err_dv_count", n_dv, 0);
        stp_err = 1'b0;

        // Start glitch: line low two cycles, start checker rejects.
        clr_stats(); strt_glitch = 1'b1;
        frame(1, -1, 6'd0, len, d);
        check("gl_len", len, 8);
        check("gl_deser_count", n_deser, 0);
        check("gl_bit_cnt", int'(bit_cnt), 0);
        check("gl_edge_cnt", int'(edge_cnt), 0);
        check("gl_dv_count", n_dv, 0);
        strt_glitch = 1'b0;

        // Ratio change mid-frame takes effect only on the next frame.
        clr_stats(); chk_exp = 14; prescale = 6'd16;
        frame(0, 40, 6'd32, len, d);
        check("ps_chg_len16", len, 160);
        check("ps_chg_deser16", deser_bad, 0);
        clr_stats(); chk_exp = 30;
        frame(0, -1, 6'd0, len, d);
        check("ps_chg_len32", len, 320);
        check("ps_chg_deser32", deser_bad, 0);
        check("ps_chg_dv", n_dv, 1);

        // Illegal ratio falls back to 8x.
        clr_stats(); chk_exp = 6; prescale = 6'd12;
        frame(0, -1, 6'd0, len, d);
        check("ps_illegal_len", len, 80);

        // Back-to-back frames at 8x.
        clr_stats(); prescale = 6'd8;
        frame(0, -1, 6'd0, len, d);
        dv_first = dv_cyc;
        frame(0, -1, 6'd0, len, d);
        check("b2b_dv_count", n_dv, 2);
        check("b2b_dv_spacing", dv_cyc - dv_first, 81);

        // Asynchronous reset in the middle of the data bits.
        clr_stats();
        rx_in = 1'b0;
        step();
        rx_in = 1'b1;
        nb = 0;
        while (int'(bit_cnt) != 4 && nb < 200) begin step(); nb++; end
        check("mid_reached_bit4", int'(bit_cnt), 4);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_samp_en", int'(dat_samp_en), 0);
        check("mid_rst_edge_cnt", int'(edge_cnt), 0);
        check("mid_rst_bit_cnt", int'(bit_cnt), 0);
        check("mid_rst_strobes", int'({strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_idle", int'(dat_samp_en), 0);
        clr_stats();
        frame(0, -1, 6'd0, len, d);
        check("post_rst_len", len, 80);
        check("post_rst_dv", n_dv, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
